instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch front end: in-order requests with a credit limit of two,
// a two-entry response buffer, and redirect handling through a flush state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_CODE = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_code,
  output logic [31:0] instr_pc
);

  // state    | meaning
  // ST_RUN   | issuing requests, buffering in-order responses
  // ST_FLUSH | no requests; draining responses that predate a redirect
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [29:0] pc_word;
  logic [29:0] pc_word_nxt;
  logic [1:0]  outstanding;
  logic [1:0]  outstanding_nxt;

  logic [31:0] fifo_data [2];
  logic [31:0] fifo_pc   [2];
  logic        fifo_wr_ptr;
  logic        fifo_rd_ptr;
  logic [1:0]  fifo_count;

  logic [31:0] aq_pc [2];
  logic        aq_wr_ptr;
  logic        aq_rd_ptr;

  logic [2:0]  credit_used;
  logic        req_hs;
  logic        rsp_take;
  logic        fifo_push;
  logic        fifo_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
    instr_valid     = (fifo_count != 2'd0);
    imem_req_valid  = 1'b0;
    req_hs          = 1'b0;
    rsp_take        = 1'b0;
    fifo_push       = 1'b0;
    fifo_pop        = 1'b0;
    outstanding_nxt = outstanding;
    pc_word_nxt     = pc_word;
    state_nxt       = state;

    // Credit uses only registered counts; a pop this cycle frees nothing yet.
    imem_req_valid = !rst && (state == ST_RUN) && (credit_used < 3'd2);
    req_hs         = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (outstanding != 2'd0);
    fifo_push      = rsp_take && (state == ST_RUN) && !redirect_valid;
    fifo_pop       = instr_valid && !stall && !redirect_valid;

    case ({req_hs, rsp_take})
      2'b10:   outstanding_nxt = outstanding + 2'd1;
      2'b01:   outstanding_nxt = outstanding - 2'd1;
      default: outstanding_nxt = outstanding;
    endcase

    if (redirect_valid) begin
      pc_word_nxt = redirect_pc[31:2];
    end else if (req_hs) begin
      pc_word_nxt = pc_word + 30'd1;
    end

    case (state)
      ST_RUN: begin
        if (redirect_valid && (outstanding_nxt != 2'd0)) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (outstanding_nxt == 2'd0) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_word     <= RESET_PC[31:2];
      outstanding <= 2'd0;
    end else begin
      pc_word     <= pc_word_nxt;
      outstanding <= outstanding_nxt;
    end
  end

  // Response buffer bookkeeping; a redirect empties both queues at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
      aq_wr_ptr   <= 1'b0;
      aq_rd_ptr   <= 1'b0;
    end else if (redirect_valid) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
      aq_wr_ptr   <= 1'b0;
      aq_rd_ptr   <= 1'b0;
    end else begin
      if (fifo_push) begin
        fifo_wr_ptr <= ~fifo_wr_ptr;
        aq_rd_ptr   <= ~aq_rd_ptr;
      end
      if (fifo_pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (req_hs) begin
        aq_wr_ptr <= ~aq_wr_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[fifo_wr_ptr] <= imem_rsp_data;
      fifo_pc[fifo_wr_ptr]   <= aq_pc[aq_rd_ptr];
    end
    if (req_hs && !redirect_valid) begin
      aq_pc[aq_wr_ptr] <= {pc_word, 2'b00};
    end
  end

  assign imem_req_addr = {pc_word, 2'b00};
  assign instr_code    = instr_valid ? fifo_data[fifo_rd_ptr] : NOP_CODE;
  assign instr_pc      = instr_valid ? fifo_pc[fifo_rd_ptr] : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model, in-order memory with
// random latency, directed scenarios followed by randomized traffic.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;

  logic        w_rst;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_stall;
  logic        w_instr_valid;
  logic [31:0] w_instr_code;
  logic [31:0] w_instr_pc;

  instr_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .instr_valid(instr_valid),
    .instr_code(instr_code), .instr_pc(instr_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .stall(w_stall), .instr_valid(w_instr_valid),
    .instr_code(w_instr_code), .instr_pc(w_instr_pc)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: fetch pc, in-flight count, flush flag, queues
  logic [31:0] m_pc;
  int          m_out;
  bit          m_flush;
  logic [63:0] fifo_q[$];
  logic [31:0] aq[$];

  // in-order memory
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due;
  int          cyc;
  int          lat_min;
  int          lat_max;

  logic        obs_iv;
  logic        obs_hs;
  logic [31:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_0000;
    m_out   = 0;
    m_flush = 1'b0;
    fifo_q.delete();
    aq.delete();
  endtask

  task automatic step(input logic r, input logic rdy, input logic stl,
                      input logic rv, input logic [31:0] rp);
    logic        e_rv;
    logic        e_iv;
    logic [31:0] e_code;
    logic [31:0] e_pc;
    logic        hs;
    logic        take;
    logic        mrsp;
    logic [31:0] mdata;
    logic [31:0] head_pc;
    int          new_out;
    int          due;

    rst            = r;
    imem_req_ready = rdy;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rp;
    mrsp  = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    mdata = mrsp ? (pend_addr[0] ^ 32'hC3A5_0F0F) : $urandom;
    imem_rsp_valid = mrsp;
    imem_rsp_data  = mdata;
    #1;
    e_rv   = !r && !m_flush && ((m_out + fifo_q.size()) < 2);
    e_iv   = (fifo_q.size() > 0);
    e_code = e_iv ? fifo_q[0][63:32] : NOP;
    e_pc   = e_iv ? fifo_q[0][31:0] : 32'h0000_0000;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, e_rv});
    if (e_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_iv});
    chk("instr_code", instr_code, e_code);
    chk("instr_pc", instr_pc, e_pc);
    obs_iv   = instr_valid;
    obs_hs   = imem_req_valid && rdy;
    obs_addr = imem_req_addr;
    hs = e_rv && rdy;

    @(posedge clk);
    #1;
    if (mrsp) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (hs) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due < last_due) due = last_due;
      last_due = due;
      pend_addr.push_back(m_pc);
      pend_due.push_back(due);
    end

    if (r) begin
      model_reset();
    end else begin
      take    = mrsp && (m_out > 0);
      new_out = m_out + (hs ? 1 : 0) - (take ? 1 : 0);
      if (rv) begin
        fifo_q.delete();
        aq.delete();
        m_pc    = {rp[31:2], 2'b00};
        m_flush = (new_out > 0);
      end else if (m_flush) begin
        m_flush = (new_out > 0);
      end else begin
        if ((fifo_q.size() > 0) && !stl) void'(fifo_q.pop_front());
        if (take) begin
          head_pc = aq.pop_front();
          fifo_q.push_back({mdata, head_pc});
        end
        if (hs) begin
          aq.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      m_out = new_out;
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] w_addrs [3];
    logic [31:0] exp_wrap [3];
    logic [31:0] held;
    logic [31:0] redir_addr;
    int          w_n;
    int          first_valid;
    int          n;
    bit          seen;

    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    w_rst = 1'b1; w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 32'h0000_0013;
    w_redirect_valid = 1'b0; w_redirect_pc = '0; w_stall = 1'b0;
    cyc = 0; last_due = 0; lat_min = 1; lat_max = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // wrap-around from a high reset pc
    exp_wrap[0] = 32'hFFFF_FFF8;
    exp_wrap[1] = 32'hFFFF_FFFC;
    exp_wrap[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) w_addrs[i] = 32'hDEAD_BEEF;
    w_n   = 0;
    w_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_rsp_valid = (w_n > 0);
      #1;
      if (w_req_valid && w_req_ready) begin
        if (w_n < 3) w_addrs[w_n] = w_req_addr;
        w_n++;
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) chk("wrap_addr", w_addrs[i], exp_wrap[i]);
    w_rst = 1'b1;

    // reset, then streaming with a 1-cycle memory
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    first_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (obs_iv && (first_valid == 0)) first_valid = k;
    end
    chk("first_valid_cycle", first_valid, 32'd3);

    // decode stall mid-stream
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // redirect with two requests in flight
    lat_min = 4; lat_max = 4;
    n = 0;
    while ((m_out < 2) && (n < 10)) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1002);
    seen = 1'b0;
    redir_addr = 32'hDEAD_BEEF;
    n = 0;
    while (!seen && (n < 20)) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (obs_hs) begin
        seen = 1'b1;
        redir_addr = obs_addr;
      end
      n++;
    end
    chk("redirect_addr", redir_addr, 32'h0000_1000);

    // memory not ready: address must hold
    lat_min = 1; lat_max = 1;
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    held = m_pc;
    repeat (4) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("hold_addr", obs_addr, held);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("hs_addr", obs_addr, held);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("post_hs_addr", obs_addr, held + 32'd4);

    // randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199, 0) == 0),
           ($urandom_range(3, 0) != 0),
           ($urandom_range(2, 0) == 0),
           ($urandom_range(15, 0) == 0),
           $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
